fmc_adc_pattern_gen: RTL and testbench



---
 rtl/fmc_adc_pattern_pkg.sv | 31 +++
 rtl/fmc_adc_pattern_gen_if.sv | 26 ++
 rtl/fmc_adc_pattern_chan.sv | 107 ++++++++++
 rtl/fmc_adc_pattern_gen.sv | 92 +++++++++
 tb/tb_fmc_adc_pattern_gen.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/fmc_adc_pattern_pkg.sv
// rtl/fmc_adc_pattern_pkg.sv - shared types, limits and LFSR step for the FMC-ADC pattern generator
package fmc_adc_pattern_pkg;

    typedef enum logic [1:0] {
        TRIANGLE = 2'd0,
        RAMP     = 2'd1,
        CONSTANT = 2'd2,
        LFSR     = 2'd3
    } t_pattern_mode;

    localparam int c_MAX_NCHAN = 8;
    localparam int c_MIN_NCHAN = 1;
    localparam int c_MIN_WIDTH = 8;
    localparam int c_MAX_WIDTH = 16;

    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

    // Odd channels start counting down.
    localparam logic [c_MAX_NCHAN-1:0] c_DIR_RESET = 8'hAA;

    // Right-shifting Fibonacci form: tap n of the polynomial reads state bit 16-n.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < 16; i++) begin
            fb = fb ^ (c_LFSR_TAPS[15-i] & s[i]);
        end
        return {fb, s[15:1]};
    endfunction

endpackage

// File: rtl/fmc_adc_pattern_gen_if.sv
// rtl/fmc_adc_pattern_gen_if.sv - configuration and sample bus of the FMC-ADC pattern generator
interface fmc_adc_pattern_gen_if #(
    parameter int g_NCHAN = 4,
    parameter int g_WIDTH = 14
);
    logic                         enable_i;
    logic [1:0]                   mode_i;
    logic [g_WIDTH-1:0]           step_i;
    logic [g_WIDTH-1:0]           limit_i;
    logic [15:0]                  decim_i;
    logic [g_NCHAN*g_WIDTH-1:0]   data_o;
    logic                         valid_o;
    logic [g_NCHAN-1:0]           dir_o;
    logic [31:0]                  sample_cnt_o;
    logic                         cfg_err_o;

    modport master (
        input  enable_i, mode_i, step_i, limit_i, decim_i,
        output data_o, valid_o, dir_o, sample_cnt_o, cfg_err_o
    );

    modport slave (
        output enable_i, mode_i, step_i, limit_i, decim_i,
        input  data_o, valid_o, dir_o, sample_cnt_o, cfg_err_o
    );
endinterface

// File: rtl/fmc_adc_pattern_chan.sv
// rtl/fmc_adc_pattern_chan.sv - one channel's value/direction/LFSR; LFSR built only with FMC_ADC_PATTERN_LFSR_EN
module fmc_adc_pattern_chan
    import fmc_adc_pattern_pkg::*;
#(
    parameter int g_WIDTH = 14
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [2:0]          k,
    input  logic                tick,
    input  logic                reload,
    input  t_pattern_mode       mode,
    input  logic [g_WIDTH-1:0]  step,
    input  logic [g_WIDTH-1:0]  limit,
    input  logic                err,
    output logic [g_WIDTH-1:0]  sample,
    output logic                dir
);

    logic signed [g_WIDTH-1:0] x_q, x_cur, x_nxt;
    logic                      dir_q, dir_cur, dir_nxt;
    logic signed [g_WIDTH:0]   x_ext, step_ext, limit_ext, up_sum, dn_sum;

    // A mode change restarts the channel, and that restart value is what gets emitted.
    assign x_cur   = reload ? '0 : x_q;
    assign dir_cur = reload ? k[0] : dir_q;
    assign dir     = dir_cur;

    assign x_ext     = {x_cur[g_WIDTH-1], x_cur};
    assign step_ext  = {1'b0, step};
    assign limit_ext = {1'b0, limit};
    assign up_sum    = x_ext + step_ext;
    assign dn_sum    = x_ext - step_ext;

`ifdef FMC_ADC_PATTERN_LFSR_EN
    logic [15:0] lfsr_q, lfsr_cur, seed;

    assign seed     = 16'(k) + 16'd1;
    assign lfsr_cur = reload ? seed : lfsr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= seed;
        end else if (tick) begin
            lfsr_q <= (mode == LFSR && !err) ? lfsr_next(lfsr_cur) : lfsr_cur;
        end
    end
`else
    logic unused_k;
    assign unused_k = ^k[2:1];
`endif

    always_comb begin
        sample = '0;
        if (!err) begin
            case (mode)
                TRIANGLE, RAMP: sample = x_cur;
                CONSTANT:       sample = limit;
`ifdef FMC_ADC_PATTERN_LFSR_EN
                LFSR:           sample = lfsr_cur[g_WIDTH-1:0];
`else
                LFSR:           sample = '0;
`endif
                default:        sample = '0;
            endcase
        end
    end

    always_comb begin
        x_nxt   = x_cur;
        dir_nxt = dir_cur;
        if (!err) begin
            case (mode)
                TRIANGLE: begin
                    if (!dir_cur) begin
                        if (up_sum > limit_ext) begin
                            dir_nxt = 1'b1;
                            x_nxt   = dn_sum[g_WIDTH-1:0];
                        end else begin
                            x_nxt   = up_sum[g_WIDTH-1:0];
                        end
                    end else begin
                        if (dn_sum < -limit_ext) begin
                            dir_nxt = 1'b0;
                            x_nxt   = up_sum[g_WIDTH-1:0];
                        end else begin
                            x_nxt   = dn_sum[g_WIDTH-1:0];
                        end
                    end
                end
                RAMP:    x_nxt = up_sum[g_WIDTH-1:0];
                default: x_nxt = x_cur;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q   <= '0;
            dir_q <= k[0];
        end else if (tick) begin
            x_q   <= x_nxt;
            dir_q <= dir_nxt;
        end
    end

endmodule

// File: rtl/fmc_adc_pattern_gen.sv
// rtl/fmc_adc_pattern_gen.sv - N-channel decimated test-pattern source; LFSR mode needs FMC_ADC_PATTERN_LFSR_EN
module fmc_adc_pattern_gen
    import fmc_adc_pattern_pkg::*;
#(
    parameter int g_NCHAN = 4,
    parameter int g_WIDTH = 14
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    fmc_adc_pattern_gen_if.master  bus
);

    logic [15:0]                 dec_cnt;
    logic                        tick;
    logic                        reload;
    logic                        err_now;
    t_pattern_mode               mode_q;
    t_pattern_mode               mode_now;
    logic [g_NCHAN*g_WIDTH-1:0]  sample_bus;
    logic [g_NCHAN-1:0]          dir_bus;

    logic [g_NCHAN*g_WIDTH-1:0]  data_q;
    logic                        valid_q;
    logic [g_NCHAN-1:0]          dir_q;
    logic [31:0]                 cnt_q;
    logic                        err_q;

    // Equality compare lets a decim_i lowered mid-count run the counter round through 0xFFFF.
    assign tick     = bus.enable_i && (dec_cnt == bus.decim_i);
    assign mode_now = t_pattern_mode'(bus.mode_i);
    assign reload   = tick && (mode_now != mode_q);

`ifdef FMC_ADC_PATTERN_LFSR_EN
    assign err_now = (mode_now == TRIANGLE) && (bus.step_i > bus.limit_i);
`else
    assign err_now = ((mode_now == TRIANGLE) && (bus.step_i > bus.limit_i)) ||
                     (mode_now == LFSR);
`endif

    for (genvar k = 0; k < g_NCHAN; k++) begin : g_chan
        fmc_adc_pattern_chan #(
            .g_WIDTH (g_WIDTH)
        ) u_chan (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .k      (3'(k)),
            .tick   (tick),
            .reload (reload),
            .mode   (mode_now),
            .step   (bus.step_i),
            .limit  (bus.limit_i),
            .err    (err_now),
            .sample (sample_bus[k*g_WIDTH +: g_WIDTH]),
            .dir    (dir_bus[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dec_cnt <= '0;
        end else if (bus.enable_i) begin
            dec_cnt <= tick ? 16'd0 : dec_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            dir_q   <= c_DIR_RESET[g_NCHAN-1:0];
            cnt_q   <= '0;
            err_q   <= 1'b0;
            mode_q  <= TRIANGLE;
        end else begin
            valid_q <= tick;
            if (tick) begin
                data_q <= sample_bus;
                dir_q  <= dir_bus;
                cnt_q  <= cnt_q + 32'd1;
                err_q  <= err_now;
                mode_q <= mode_now;
            end
        end
    end

    assign bus.data_o       = data_q;
    assign bus.valid_o      = valid_q;
    assign bus.dir_o        = dir_q;
    assign bus.sample_cnt_o = cnt_q;
    assign bus.cfg_err_o    = err_q;

endmodule

// File: tb/tb_fmc_adc_pattern_gen.sv
// tb/tb_fmc_adc_pattern_gen.sv - directed self-checking bench; mode-3 expectations follow FMC_ADC_PATTERN_LFSR_EN
module tb_fmc_adc_pattern_gen;

    localparam int NCH = 4;
    localparam int W   = 14;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fmc_adc_pattern_gen_if #(.g_NCHAN(NCH), .g_WIDTH(W)) bus ();

    fmc_adc_pattern_gen #(
        .g_NCHAN (NCH),
        .g_WIDTH (W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ch(input int k);
        return 32'(bus.data_o[k*W +: W]);
    endfunction

    function automatic logic [31:0] w14(input int v);
        logic [W-1:0] t;
        t = W'(v);
        return 32'(t);
    endfunction

    // Closed-form triangle for step 8, limit 400, starting upward at 0.
    function automatic int tri_val(input int n);
        int p;
        p = n % 200;
        if (p <= 50)       return 8 * p;
        else if (p <= 150) return 400 - 8 * (p - 50);
        else               return -400 + 8 * (p - 150);
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int exp);
        for (int k = 0; k < NCH; k++) begin
            check_val($sformatf("%s_ch%0d", tag, k), ch(k), w14(exp));
        end
    endtask

    initial begin
        int p;
        logic d0;
        int rv[5];
        rv = '{0, 'h1000, 'h2000, 'h3000, 0};

        rst          = 1'b1;
        bus.enable_i = 1'b0;
        bus.mode_i   = 2'd0;
        bus.step_i   = 14'd8;
        bus.limit_i  = 14'd400;
        bus.decim_i  = 16'd0;
        step_clk();
        step_clk();
        check_all("rst_data", 0);
        check_val("rst_valid", 32'(bus.valid_o), 32'd0);
        check_val("rst_cnt", bus.sample_cnt_o, 32'd0);
        check_val("rst_err", 32'(bus.cfg_err_o), 32'd0);
        check_val("rst_dir", 32'(bus.dir_o), 32'hA);

        rst          = 1'b0;
        bus.enable_i = 1'b1;
        for (int n = 0; n < 210; n++) begin
            step_clk();
            p  = n % 200;
            d0 = (p >= 51) && (p <= 150);
            check_val($sformatf("tri_ch0_%0d", n), ch(0), w14(tri_val(n)));
            check_val($sformatf("tri_ch1_%0d", n), ch(1), w14(-tri_val(n)));
            check_val($sformatf("tri_valid_%0d", n), 32'(bus.valid_o), 32'd1);
            check_val($sformatf("tri_dir_%0d", n), 32'(bus.dir_o), 32'({!d0, d0, !d0, d0}));
            check_val($sformatf("tri_cnt_%0d", n), bus.sample_cnt_o, 32'(n + 1));
        end

        bus.mode_i = 2'd1;
        bus.step_i = 14'h1000;
        for (int i = 0; i < 5; i++) begin
            step_clk();
            check_val($sformatf("ramp_ch0_%0d", i), ch(0), 32'(rv[i]));
            check_val($sformatf("ramp_ch3_%0d", i), ch(3), 32'(rv[i]));
            check_val($sformatf("ramp_valid_%0d", i), 32'(bus.valid_o), 32'd1);
        end

        bus.mode_i  = 2'd0;
        bus.step_i  = 14'd8;
        bus.limit_i = 14'd400;
        step_clk();
        check_all("sw_first", 0);
        check_val("sw_dir", 32'(bus.dir_o), 32'hA);
        step_clk();
        check_val("sw_ch0", ch(0), w14(8));
        check_val("sw_ch1", ch(1), w14(-8));
        check_val("sw_cnt", bus.sample_cnt_o, 32'd217);

        rst = 1'b1;
        step_clk();
        check_all("mid_rst_data", 0);
        check_val("mid_rst_valid", 32'(bus.valid_o), 32'd0);
        check_val("mid_rst_cnt", bus.sample_cnt_o, 32'd0);
        check_val("mid_rst_err", 32'(bus.cfg_err_o), 32'd0);
        check_val("mid_rst_dir", 32'(bus.dir_o), 32'hA);

        rst         = 1'b0;
        bus.mode_i  = 2'd2;
        bus.limit_i = 14'h155;
        bus.decim_i = 16'd4;
        for (int i = 1; i <= 50; i++) begin
            step_clk();
            check_val($sformatf("dec_valid_%0d", i), 32'(bus.valid_o), 32'((i % 5) == 0));
            if (i >= 5) check_all($sformatf("const_%0d", i), 'h155);
        end
        check_val("dec_cnt50", bus.sample_cnt_o, 32'd10);

        bus.decim_i = 16'd0;
        bus.mode_i  = 2'd0;
        bus.step_i  = 14'd10;
        bus.limit_i = 14'd5;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            check_val($sformatf("cfgerr_flag_%0d", i), 32'(bus.cfg_err_o), 32'd1);
            check_val($sformatf("cfgerr_valid_%0d", i), 32'(bus.valid_o), 32'd1);
            check_all($sformatf("cfgerr_data_%0d", i), 0);
        end
        bus.limit_i = 14'd20;
        step_clk();
        check_val("cfgerr_clear", 32'(bus.cfg_err_o), 32'd0);
        check_val("cfgerr_clear_valid", 32'(bus.valid_o), 32'd1);
        check_val("cfgerr_cnt", bus.sample_cnt_o, 32'd14);

        bus.enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            check_val($sformatf("hold_valid_%0d", i), 32'(bus.valid_o), 32'd0);
            check_val($sformatf("hold_cnt_%0d", i), bus.sample_cnt_o, 32'd14);
        end

        bus.enable_i = 1'b1;
        bus.mode_i   = 2'd3;
`ifdef FMC_ADC_PATTERN_LFSR_EN
        step_clk();
        check_val("lfsr_ch0_0", ch(0), 32'h0001);
        check_val("lfsr_ch1_0", ch(1), 32'h0002);
        check_val("lfsr_err", 32'(bus.cfg_err_o), 32'd0);
        step_clk();
        check_val("lfsr_ch0_1", ch(0), 32'h0000);
        step_clk();
        check_val("lfsr_ch0_2", ch(0), 32'h0000);
        step_clk();
        check_val("lfsr_ch0_3", ch(0), 32'h2000);
`else
        for (int i = 0; i < 3; i++) begin
            step_clk();
            check_all($sformatf("nolfsr_data_%0d", i), 0);
            check_val($sformatf("nolfsr_err_%0d", i), 32'(bus.cfg_err_o), 32'd1);
            check_val($sformatf("nolfsr_valid_%0d", i), 32'(bus.valid_o), 32'd1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
